// File: rtl/addr_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : addr_fifo_push_arbiter
// Description : Round-robin arbiter sharing one address-FIFO enqueue port
//               across NUM_REQ requesters, with per-requester occupancy caps.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_fifo_push_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int MAX_PER_REQ = 2,
    localparam int ID_W       = $clog2(NUM_REQ),
    localparam int CNT_W      = $clog2(MAX_PER_REQ) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic                        fifo_push,
    output logic                        fifo_potential_push,
    output logic [ID_W+ADDR_W-1:0]      fifo_data_in,
    input  logic                        fifo_full,
    input  logic                        fifo_valid,
    input  logic                        fifo_pop,
    input  logic [ID_W-1:0]             fifo_head_id,
    output logic [NUM_REQ*CNT_W-1:0]    outstanding
);

    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_PER_REQ);
    localparam logic [ID_W:0]    c_num_req = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  c_last_id = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  outstanding_q [NUM_REQ];
    logic [CNT_W-1:0]  outstanding_d [NUM_REQ];

    logic [ADDR_W-1:0] w_addr [NUM_REQ];
    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_inc;
    logic [NUM_REQ-1:0] w_dec;
    logic              w_any_eligible;
    logic              w_can_push;
    logic              w_push;
    logic [ID_W-1:0]   w_grant_id;
    logic [ID_W:0]     w_scan_idx;

    // Eligibility uses the registered count only; a pop this cycle does not
    // free a slot until the next edge. Reset masks all requests.
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
            assign w_addr[g]     = req_addr[g*ADDR_W +: ADDR_W];
            assign w_eligible[g] = !rst && req_valid[g] && (outstanding_q[g] < c_max_cnt);
            assign w_inc[g]      = w_push && (w_grant_id == ID_W'(g));
            assign w_dec[g]      = fifo_pop && (fifo_head_id == ID_W'(g)) && (outstanding_q[g] != '0);
            assign outstanding[g*CNT_W +: CNT_W] = outstanding_q[g];
        end
    endgenerate

    always_comb begin
        w_any_eligible = 1'b0;
        w_grant_id     = '0;
        w_scan_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (w_scan_idx >= c_num_req) begin
                w_scan_idx = w_scan_idx - c_num_req;
            end
            if (!w_any_eligible && w_eligible[w_scan_idx[ID_W-1:0]]) begin
                w_any_eligible = 1'b1;
                w_grant_id     = w_scan_idx[ID_W-1:0];
            end
        end
    end

    assign w_can_push          = !fifo_full || fifo_pop;
    assign w_push              = w_any_eligible && w_can_push;
    assign fifo_push           = w_push;
    assign fifo_potential_push = w_any_eligible;
    assign fifo_data_in        = {w_grant_id, w_addr[w_grant_id]};

    always_comb begin
        req_ack = '0;
        if (w_push) begin
            req_ack[w_grant_id] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_push) begin
            rr_ptr_d = (w_grant_id == c_last_id) ? '0 : w_grant_id + ID_W'(1);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            outstanding_d[i] = outstanding_q[i];
            if (w_inc[i] && !w_dec[i]) begin
                outstanding_d[i] = outstanding_q[i] + CNT_W'(1);
            end else if (w_dec[i] && !w_inc[i]) begin
                outstanding_d[i] = outstanding_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                outstanding_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                outstanding_q[i] <= outstanding_d[i];
            end
        end
    end

    a_pop_has_source: assert property (@(posedge clk) disable iff (rst)
        fifo_pop |-> (fifo_valid || fifo_push));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        fifo_pop |-> (outstanding_q[fifo_head_id] != '0));
    a_push_has_room: assert property (@(posedge clk) disable iff (rst)
        fifo_push |-> (!fifo_full || fifo_pop));
    a_ack_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ack));

endmodule
`default_nettype wire
